// File: rtl/mips_dmem_ws_pkg.sv
// mips_mem_pkg: shared definitions for the wait-stated MIPS data memory.
//   DATA_W  : data bus width (32)
//   size_e  : access size encodings (byte/half/word/reserved)
//   state_e : controller states (IDLE/BUSY/RESP/CLEAR)
package mips_mem_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    RESP  = 2'b10,
    CLEAR = 2'b11
  } state_e;
endpackage

// File: rtl/mips_dmem_ws_if.sv
// mips_dmem_ws_if: CPU <-> data memory request/response bundle.
//   master : CPU side, drives CPU_MIO/mem_w/addr_in/wdata_in/size/sign_ext,
//            receives rdata_out/MIO_ready/err
//   slave  : memory side, the mirror image
interface mips_dmem_ws_if;
  import mips_mem_pkg::*;

  logic              CPU_MIO;
  logic              mem_w;
  logic [DATA_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [1:0]        size;
  logic              sign_ext;
  logic [DATA_W-1:0] rdata_out;
  logic              MIO_ready;
  logic              err;

  modport master (
    output CPU_MIO, mem_w, addr_in, wdata_in, size, sign_ext,
    input  rdata_out, MIO_ready, err
  );

  modport slave (
    input  CPU_MIO, mem_w, addr_in, wdata_in, size, sign_ext,
    output rdata_out, MIO_ready, err
  );
endinterface

// File: rtl/mips_dmem_ws_lane.sv
// mips_mem_lane: combinational lane steering for byte/half/word accesses.
//   size_i     : access size encoding
//   lane_i     : byte offset inside the addressed word
//   sign_ext_i : sign- (1) or zero- (0) extend byte/half reads
//   wdata_i    : right-justified write data
//   rword_i    : current contents of the addressed word
//   be_o       : byte write enables (little-endian, lane 0 = [7:0])
//   wdata_o    : write data replicated into every lane position
//   rdata_o    : extracted and extended read data
//   misalign_o : misaligned access or reserved size
module mips_mem_lane
  import mips_mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              sign_ext_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o
);
  logic [DATA_W-1:0] shifted;

  // Bring the addressed lane down to bit 0; for an aligned word this is a no-op.
  assign shifted = rword_i >> {lane_i, 3'b000};

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = shifted;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign_o = lane_i[0];
        be_o       = 4'b0011 << lane_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign_o = (lane_i != 2'b00);
        be_o       = 4'b1111;
      end
      default: misalign_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_dmem_ws.sv
// mips_dmem_ws: wait-stated data memory for the single-cycle MIPS core.
//   clk   : system clock, posedge
//   reset : synchronous active-low reset
//   bus   : slave side of mips_dmem_ws_if (request in, rdata/MIO_ready/err out)
// Optional feature: define MEM_CLEAR_EN to zero the array one word per cycle
// after reset; CPU requests are ignored until the clear finishes.
module mips_dmem_ws
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          WAIT_CYC   = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mips_dmem_ws_if.slave bus
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [1:0]        size_q;
  logic              sign_q, we_q;
  logic              latch, do_write;

  logic [DATA_W-1:0]     off;
  logic                  in_range, acc_err, misalign;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [DATA_W-1:0]     wsh, rext;

`ifdef MEM_CLEAR_EN
  logic [DEPTH_LOG2-1:0] clr_q;
`endif

  // Decode against the latched request; 33-bit compare so the bound never wraps.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = {1'b0, off} < (33'd1 << (DEPTH_LOG2 + 2));
  assign idx      = off[DEPTH_LOG2+1:2];
  assign lane     = off[1:0];
  assign acc_err  = misalign | ~in_range;

  mips_mem_lane u_lane (
    .size_i     (size_q),
    .lane_i     (lane),
    .sign_ext_i (sign_q),
    .wdata_i    (wdata_q),
    .rword_i    (mem[idx]),
    .be_o       (be),
    .wdata_o    (wsh),
    .rdata_o    (rext),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    latch    = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CPU_MIO) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_CYC);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdy_d    = 1'b1;
          err_d    = acc_err;
          rdata_d  = (acc_err || we_q) ? '0 : rext;
          do_write = we_q & ~acc_err;
          state_d  = RESP;
        end
      end
      // The CPU still presents the completed request here, so it is not re-sampled.
      RESP: state_d = IDLE;
`ifdef MEM_CLEAR_EN
      CLEAR: if (&clr_q) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef MEM_CLEAR_EN
      state_q <= CLEAR;
      clr_q   <= '0;
`else
      state_q <= IDLE;
`endif
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
`ifdef MEM_CLEAR_EN
      if (state_q == CLEAR) clr_q <= clr_q + 1'b1;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q  <= bus.addr_in;
      wdata_q <= bus.wdata_in;
      size_q  <= bus.size;
      sign_q  <= bus.sign_ext;
      we_q    <= bus.mem_w;
    end
  end

  // Storage; a write coinciding with reset is dropped (aborted access).
  always_ff @(posedge clk) begin
    if (do_write && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
`ifdef MEM_CLEAR_EN
    if (reset && state_q == CLEAR) mem[clr_q] <= '0;
`endif
  end

  assign bus.MIO_ready = rdy_q;
  assign bus.err       = err_q;
  assign bus.rdata_out = rdata_q;
endmodule

// File: tb/tb_mips_dmem_ws.sv
module tb_mips_dmem_ws;
  localparam int          WAIT_A = 2;
  localparam logic [31:0] BASE_A = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_dmem_ws_if a ();
  mips_dmem_ws_if b ();

  mips_dmem_ws #(.DEPTH_LOG2(10), .WAIT_CYC(WAIT_A), .BASE_ADDR(BASE_A)) dut (
    .clk(clk), .reset(reset), .bus(a));
  mips_dmem_ws #(.DEPTH_LOG2(10), .WAIT_CYC(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .bus(b));

  int nchk = 0;
  int npass = 0;
  logic [31:0] mem_m [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: byte-addressed little-endian array with the access rules applied directly.
  function automatic void model(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                                input logic [1:0] sz, input logic sx,
                                output logic e, output logic [31:0] rd);
    int unsigned off, idx, lane, nb;
    logic [31:0] mask, v;
    off = ad - BASE_A;
    e = 1'b0;
    rd = 32'h0;
    nb = 1;
    if (sz == 2'd3) e = 1'b1;
    else begin
      nb = 1 << sz;
      if (off % nb != 0) e = 1'b1;
      if (off >= 4096) e = 1'b1;
    end
    if (!e) begin
      idx = off / 4;
      lane = off % 4;
      if (w) begin
        for (int k = 0; k < int'(nb); k++) mem_m[idx][8*(lane+k) +: 8] = wd[8*k +: 8];
      end else begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        v = (mem_m[idx] >> (8*lane)) & mask;
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~mask;
        rd = v;
      end
    end
  endfunction

  task automatic do_acc(input string tag, input logic w, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                        output logic [31:0] rd_obs);
    logic e_exp;
    logic [31:0] rd_exp;
    int k;
    logic got;
    model(w, ad, wd, sz, sx, e_exp, rd_exp);
    @(negedge clk);
    a.CPU_MIO = 1'b1; a.mem_w = w; a.addr_in = ad; a.wdata_in = wd;
    a.size = sz; a.sign_ext = sx;
    @(posedge clk);
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge clk); #1;
      k++;
      if (a.MIO_ready) got = 1'b1;
    end
    check({tag, "_ready"}, 32'(got), 32'd1);
    check({tag, "_latency"}, k, WAIT_A + 1);
    check({tag, "_err"}, 32'(a.err), 32'(e_exp));
    check({tag, "_rdata"}, a.rdata_out, rd_exp);
    rd_obs = a.rdata_out;
    a.CPU_MIO = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(a.MIO_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [1:0] sz;
    int pulses;
    int k;
    logic got;

    a.CPU_MIO = 0; a.mem_w = 0; a.addr_in = 0; a.wdata_in = 0; a.size = 0; a.sign_ext = 0;
    b.CPU_MIO = 0; b.mem_w = 0; b.addr_in = 0; b.wdata_in = 0; b.size = 0; b.sign_ext = 0;
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(a.MIO_ready), 32'd0);
    check("rst_err", 32'(a.err), 32'd0);
    check("rst_rdata", a.rdata_out, 32'd0);
    check("rst0_ready", 32'(b.MIO_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
`ifdef MEM_CLEAR_EN
    repeat (1040) @(posedge clk);
`endif

    // Give the test region known contents
    for (int i = 0; i < 17; i++) do_acc("init", 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0, rd);

    // Directed word/byte/half scenarios
    do_acc("w_dead", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd);
    check("w_dead_zero", rd, 32'h0);
    do_acc("r_dead", 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, rd);
    check("r_dead_val", rd, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rdata", a.rdata_out, 32'hDEADBEEF);
    do_acc("wb_80", 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, rd);
    do_acc("rb_s", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, rd);
    check("rb_s_val", rd, 32'hFFFFFF80);
    do_acc("rb_u", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd);
    check("rb_u_val", rd, 32'h00000080);
    do_acc("rw_mix", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
    check("rw_mix_val", rd, 32'h80ADBEEF);
    do_acc("rh_mis", 1'b0, 32'h11, 32'h0, 2'd1, 1'b1, rd);
    check("rh_mis_err", 32'(a.err), 32'd1);
    do_acc("ww_mis", 1'b1, 32'h12, 32'h12345678, 2'd2, 1'b0, rd);
    do_acc("rw_after", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
    check("rw_after_val", rd, 32'h80ADBEEF);
    do_acc("rh_hi_s", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd);
    check("rh_hi_s_val", rd, 32'hFFFF80AD);
    do_acc("oor_w", 1'b1, BASE_A + 32'd4096, 32'h5A5A5A5A, 2'd2, 1'b0, rd);
    check("oor_w_err", 32'(a.err), 32'd1);
    do_acc("oor_r", 1'b0, BASE_A + 32'd4096, 32'h0, 2'd2, 1'b0, rd);
    do_acc("rsvd", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, rd);
    do_acc("r0_chk", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd);

    // Randomized accesses against the reference
    for (int i = 0; i < 60; i++) begin
      ad = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ad = 32'h1000 + 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      do_acc($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ad, wd, sz,
             1'($urandom_range(0, 1)), rd);
    end

    // Reset during BUSY aborts the write
    @(negedge clk);
    a.CPU_MIO = 1'b1; a.mem_w = 1'b1; a.addr_in = 32'h20; a.wdata_in = 32'h11111111;
    a.size = 2'd2; a.sign_ext = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    a.CPU_MIO = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(a.MIO_ready), 32'd0);
    check("abort_err", 32'(a.err), 32'd0);
    check("abort_rdata", a.rdata_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (a.MIO_ready) pulses++;
    end
    check("abort_no_ready", pulses, 0);
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
    repeat (1040) @(posedge clk);
`endif
    do_acc("abort_rd", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd);

    // Zero-wait instance: request held for 9 cycles
    @(negedge clk);
    b.CPU_MIO = 1'b1; b.mem_w = 1'b1; b.addr_in = 32'h40; b.wdata_in = 32'hCAFEF00D;
    b.size = 2'd2; b.sign_ext = 1'b0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (b.MIO_ready) pulses++;
      check($sformatf("ws0_ready%0d", i), 32'(b.MIO_ready), 32'((i % 3) == 1));
      check($sformatf("ws0_err%0d", i), 32'(b.err), 32'd0);
    end
    check("ws0_pulses", pulses, 3);
    b.CPU_MIO = 1'b0;
    @(negedge clk);
    b.CPU_MIO = 1'b1; b.mem_w = 1'b0;
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(posedge clk); #1;
      k++;
      if (b.MIO_ready) got = 1'b1;
    end
    b.CPU_MIO = 1'b0;
    check("ws0_rd_ready", 32'(got), 32'd1);
    check("ws0_rd_lat", k, 2);
    check("ws0_rd_val", b.rdata_out, 32'hCAFEF00D);
    @(posedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
